// File: rtl/mask_scan_pkg.sv
// Shared types and helpers for the mask_scan set-bit enumerator.
package mask_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    ZERO = 2'd2
  } state_e;

  // Index width needed to address every bit of a WIDTH-bit mask.
  function automatic int calc_idxw(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/mask_scan_prio_enc.sv
// Combinational priority encoder: returns the position of the lowest (or,
// with MSB_FIRST, the highest) set bit of vec_i plus a found flag.
module mask_scan_prio_enc #(
  parameter int WIDTH     = 64,
  parameter int IDXW      = 6,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDXW-1:0]  idx_o,
  output logic             found_o
);

  // Later loop iterations overwrite earlier ones, so the scan direction is
  // chosen so that the winning bit is visited last.
  always_comb begin
    idx_o   = '0;
    found_o = |vec_i;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec_i[i]) idx_o = IDXW'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec_i[i]) idx_o = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/mask_scan.sv
// mask_scan: accepts one WIDTH-bit mask per transaction and streams the index
// of every set bit, one beat per cycle, with a last marker. An all-zero mask
// yields a single terminator beat flagged by out_empty.
// Build option: define MASK_SCAN_MSB_FIRST_EN to emit indices highest first.
//
// state | meaning
// IDLE  | ready for a new mask, no beat on the output
// SCAN  | emitting indices of the bits still set in rem
// ZERO  | emitting the single terminator beat of an all-zero mask
module mask_scan
  import mask_scan_pkg::*;
#(
  parameter  int WIDTH = 64,
  localparam int IDXW  = calc_idxw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mask_scan_in_valid_i,
  output logic             mask_scan_in_ready_o,
  input  logic [WIDTH-1:0] mask_scan_in_mask_i,
  output logic             mask_scan_out_valid_o,
  input  logic             mask_scan_out_ready_i,
  output logic [IDXW-1:0]  mask_scan_out_idx_o,
  output logic             mask_scan_out_last_o,
  output logic             mask_scan_out_empty_o,
  output logic             mask_scan_any_o,
  output logic             mask_scan_busy_o
);

`ifdef MASK_SCAN_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             any_q, any_d;

  logic [IDXW-1:0]  enc_idx;
  logic             enc_found;
  logic             rem_onehot;

  mask_scan_prio_enc #(
    .WIDTH     (WIDTH),
    .IDXW      (IDXW),
    .MSB_FIRST (MSB_FIRST)
  ) u_prio_enc (
    .vec_i   (rem_q),
    .idx_o   (enc_idx),
    .found_o (enc_found)
  );

  // Exactly one bit left: the current beat is the final one of this mask.
  always_comb begin
    rem_onehot = enc_found && ((rem_q & (rem_q - WIDTH'(1))) == '0);
  end

  // Next-state, remaining-mask update and output decode from registered state.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    any_d   = any_q;

    mask_scan_in_ready_o  = 1'b0;
    mask_scan_out_valid_o = 1'b0;
    mask_scan_out_idx_o   = '0;
    mask_scan_out_last_o  = 1'b0;
    mask_scan_out_empty_o = 1'b0;
    mask_scan_busy_o      = 1'b0;

    case (state_q)
      IDLE: begin
        mask_scan_in_ready_o = 1'b1;
        if (mask_scan_in_valid_i) begin
          rem_d   = mask_scan_in_mask_i;
          any_d   = |mask_scan_in_mask_i;
          state_d = (|mask_scan_in_mask_i) ? SCAN : ZERO;
        end
      end
      SCAN: begin
        mask_scan_out_valid_o = 1'b1;
        mask_scan_busy_o      = 1'b1;
        mask_scan_out_idx_o   = enc_idx;
        mask_scan_out_last_o  = rem_onehot;
        if (mask_scan_out_ready_i) begin
          rem_d[enc_idx] = 1'b0;
          if (rem_onehot) state_d = IDLE;
        end
      end
      ZERO: begin
        mask_scan_out_valid_o = 1'b1;
        mask_scan_busy_o      = 1'b1;
        mask_scan_out_last_o  = 1'b1;
        mask_scan_out_empty_o = 1'b1;
        if (mask_scan_out_ready_i) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      any_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      any_q   <= any_d;
    end
  end

  assign mask_scan_any_o = any_q;

endmodule

// File: tb/tb_mask_scan.sv
// Directed bench for mask_scan. Outputs are sampled 1 time unit after each
// rising edge; inputs are driven at the same point and take effect on the
// following edge.
module tb_mask_scan;

  localparam int WIDTH = 64;
  localparam int IDXW  = 6;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mask;
  logic             out_valid;
  logic             out_ready;
  logic [IDXW-1:0]  out_idx;
  logic             out_last;
  logic             out_empty;
  logic             any_o;
  logic             busy_o;

  int n_chk = 0;
  int n_err = 0;
  int exp_q[$];

  mask_scan #(.WIDTH(WIDTH)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .mask_scan_in_valid_i  (in_valid),
    .mask_scan_in_ready_o  (in_ready),
    .mask_scan_in_mask_i   (in_mask),
    .mask_scan_out_valid_o (out_valid),
    .mask_scan_out_ready_i (out_ready),
    .mask_scan_out_idx_o   (out_idx),
    .mask_scan_out_last_o  (out_last),
    .mask_scan_out_empty_o (out_empty),
    .mask_scan_any_o       (any_o),
    .mask_scan_busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one mask for a single cycle (block must be idle), then check the
  // capture-side outputs.
  task automatic send_mask(input logic [WIDTH-1:0] m, input logic exp_any);
    chk("in_ready_before_send", 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    in_mask  = m;
    step();
    in_valid = 1'b0;
    chk("busy_after_send", 64'(busy_o), 64'(1));
    chk("any_after_send", 64'(any_o), 64'(exp_any));
  endtask

  // Consume exp_q beats; toggle=1 drives out_ready 0,1,0,1... starting at 0.
  task automatic run_beats(input bit toggle, input logic exp_empty, input logic exp_any);
    int n;
    int got;
    int cyc;
    n   = exp_q.size();
    got = 0;
    cyc = 0;
    while (got < n && cyc < 400) begin
      out_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
      chk("out_valid", 64'(out_valid), 64'(1));
      chk("in_ready_busy", 64'(in_ready), 64'(0));
      chk("out_idx", 64'(out_idx), 64'(exp_q[got]));
      chk("out_last", 64'(out_last), 64'(got == n - 1));
      chk("out_empty", 64'(out_empty), 64'(exp_empty));
      if (out_ready) got++;
      step();
      cyc++;
    end
    out_ready = 1'b0;
    if (got < n) chk("beat_timeout", 64'(got), 64'(n));
    chk("idle_out_valid", 64'(out_valid), 64'(0));
    chk("idle_in_ready", 64'(in_ready), 64'(1));
    chk("idle_busy", 64'(busy_o), 64'(0));
    chk("any_hold", 64'(any_o), 64'(exp_any));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mask   = '0;
    out_ready = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_idx", 64'(out_idx), 64'(0));
    chk("rst_last", 64'(out_last), 64'(0));
    chk("rst_empty", 64'(out_empty), 64'(0));
    chk("rst_any", 64'(any_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    rst_n = 1'b1;
    step();

    // Mask 0x29 -> bits 0,3,5
    send_mask(64'h0000_0000_0000_0029, 1'b1);
`ifdef MASK_SCAN_MSB_FIRST_EN
    exp_q = {5, 3, 0};
`else
    exp_q = {0, 3, 5};
`endif
    run_beats(1'b0, 1'b0, 1'b1);

    // All-zero mask -> single terminator beat
    send_mask(64'h0, 1'b0);
    exp_q = {0};
    run_beats(1'b0, 1'b1, 1'b0);

    // Bits 0 and 63 with out_ready toggling
    send_mask(64'h8000_0000_0000_0001, 1'b1);
`ifdef MASK_SCAN_MSB_FIRST_EN
    exp_q = {63, 0};
`else
    exp_q = {0, 63};
`endif
    run_beats(1'b1, 1'b0, 1'b1);

    // Only the top bit set
    send_mask(64'h8000_0000_0000_0000, 1'b1);
    exp_q = {63};
    run_beats(1'b0, 1'b0, 1'b1);

    // All ones with in_valid held high; the next mask waits until completion
    in_valid = 1'b1;
    in_mask  = '1;
    step();
    in_mask = 64'h10;
    chk("ones_any", 64'(any_o), 64'(1));
    exp_q.delete();
    for (int i = 0; i < WIDTH; i++) begin
`ifdef MASK_SCAN_MSB_FIRST_EN
      exp_q.push_back(WIDTH - 1 - i);
`else
      exp_q.push_back(i);
`endif
    end
    run_beats(1'b0, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    exp_q = {4};
    run_beats(1'b0, 1'b0, 1'b1);

    // Reset after two beats of 0xFF
    send_mask(64'hFF, 1'b1);
    out_ready = 1'b1;
`ifdef MASK_SCAN_MSB_FIRST_EN
    chk("mid_beat0", 64'(out_idx), 64'(7));
    step();
    chk("mid_beat1", 64'(out_idx), 64'(6));
`else
    chk("mid_beat0", 64'(out_idx), 64'(0));
    step();
    chk("mid_beat1", 64'(out_idx), 64'(1));
`endif
    step();
    rst_n     = 1'b0;
    out_ready = 1'b0;
    step();
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    chk("midrst_any", 64'(any_o), 64'(0));
    rst_n = 1'b1;
    step();
    chk("midrst_still_idle", 64'(out_valid), 64'(0));
    send_mask(64'h10, 1'b1);
    exp_q = {4};
    run_beats(1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mask_scan.md
Name: mask_scan

Overview:
- Inverse companion of the vector OR-reduction. The reduction answers "is any bit set"; this block answers "which bits are set".
- Accepts one WIDTH-bit mask per transaction, for example a ReLU-positive mask or an argmax tie mask from the non-linear ops datapath.
- Emits the index of every set bit, one per cycle, over a valid/ready stream, with a last marker.
- Sits between the comparison/activation stage and index-driven gather logic.

Parameters:
- WIDTH, 64, mask width in bits; must be ≥2.
- IDXW, $clog2(WIDTH), index width; derived, not overridden.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- mask_scan_in_valid_i  input  1  mask offered
- mask_scan_in_ready_o  output  1  block can accept a mask
- mask_scan_in_mask_i  input  WIDTH  mask to enumerate
- mask_scan_out_valid_o  output  1  index beat valid
- mask_scan_out_ready_i  input  1  downstream accepts beat
- mask_scan_out_idx_o  output  IDXW  bit position of current set bit
- mask_scan_out_last_o  output  1  final beat of this mask
- mask_scan_out_empty_o  output  1  beat is the terminator for an all-zero mask
- mask_scan_any_o  output  1  registered OR-reduction of the captured mask
- mask_scan_busy_o  output  1  transaction in progress

Behaviour:
- Reset is synchronous and active-low, sampled on rising clk.
  - At reset: state=IDLE, remaining mask register=0.
  - At reset, every output is 0 except in_ready, which is 1.
- States: IDLE, SCAN, ZERO.
- IDLE:
  - in_ready=1, out_valid=0, busy=0.
  - On in_valid&&in_ready: capture the mask into rem, set any_o=|mask, set busy=1.
  - Next state is SCAN if the mask is nonzero, else ZERO.
- SCAN:
  - in_ready=0, out_valid=1.
  - out_idx = lowest set bit of rem.
  - out_last = 1 iff rem has exactly one bit set.
  - out_empty=0.
  - On out_valid&&out_ready: clear that bit in rem. If out_last, go to IDLE; otherwise stay in SCAN.
- ZERO:
  - out_valid=1, out_idx=0, out_last=1, out_empty=1.
  - On handshake: go to IDLE.
- Latency and throughput:
  - The first beat is valid on the cycle after mask acceptance.
  - One index per cycle under continuous out_ready.
  - A mask with K set bits occupies max(K,1) beats plus 1 cycle in IDLE. Back-to-back masks do not overlap.
- Backpressure: while out_valid && !out_ready, out_idx, out_last and out_empty hold stable and rem is unchanged.
- Output register behaviour:
  - any_o holds its value until the next capture.
  - The outputs are registered or driven from registered state only; there is no combinational path from mask_scan_in_mask_i to the outputs.
- Boundary cases:
  - Mask with only bit WIDTH-1 set: single beat, idx=WIDTH-1, last=1.
  - All-ones mask: WIDTH beats with idx 0..WIDTH-1; last asserts only on idx WIDTH-1.
  - in_valid while busy: ignored. The upstream source holds it, because in_ready=0.
- Reset mid-operation: rem is discarded and state returns to IDLE. out_valid is 0 from the cycle after the reset edge, and no further beats of that mask are emitted.

Optional Feature:
- Macro: MASK_SCAN_MSB_FIRST_EN.
- When defined:
  - Scan order is the highest set bit first; idx runs descending.
  - last marks the lowest set bit.
  - ZERO behaviour is unchanged.
- When undefined: LSB-first order as specified above.
- The port list is identical in both builds.

Decomposition:
- Package mask_scan_pkg holds:
  - the state enum typedef (IDLE, SCAN, ZERO);
  - the IDXW helper function.
- Sub-module prio_enc: combinational priority encoder (WIDTH → IDXW index plus a found flag).
  - LSB or MSB priority is selected by a parameter tied from the macro.
  - It is instantiated once on rem.
- The one-hot-remaining check (out_last) is computed as rem & (rem-1) == 0 inside mask_scan.

Test Plan:
- Reset, then mask 64'h0000_0000_0000_0029 with out_ready=1 → beats idx 0,3,5.
  - last=1 only on idx 5.
  - any_o=1.
  - in_ready returns to 1 one cycle after the last beat.
- Mask 0 → single beat with idx=0, last=1, empty=1; any_o=0.
- Mask 64'h8000_0000_0000_0001 with out_ready toggling 0/1 each cycle → idx 0 then 63, each held stable while ready=0. No beat is dropped or duplicated.
- All-ones mask, continuous ready → 64 consecutive beats with idx 0..63; in_valid asserted throughout is not accepted until completion.
- Mid-scan reset after 2 beats of mask 64'hFF → out_valid=0 on the next cycle, in_ready=1, and the following mask 64'h10 yields exactly idx 4.
- With MASK_SCAN_MSB_FIRST_EN defined, mask 64'h29 → idx 5,3,0 with last on idx 0.
